// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry constants and the threshold
// flag helper used by fifo_thresh.
package fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_ADDR_W = 4;

  typedef struct packed {
    logic almost_full;
    logic almost_empty;
  } thresh_flags_t;

  // Compare an occupancy count against the almost-full / almost-empty levels.
  function automatic thresh_flags_t calc_thresh(input logic [31:0] cnt,
                                                input logic [31:0] af_lvl,
                                                input logic [31:0] ae_lvl);
    thresh_flags_t f;
    f.almost_full  = (cnt >= af_lvl);
    f.almost_empty = (cnt <= ae_lvl);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_thresh: 2^ADDR_W x DATA_W registers with one
// synchronous write port and one asynchronous (show-ahead) read port.
// The array is deliberately not reset so a FIFO reset leaves contents intact.
module fifo_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write the pushed word into its slot on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous show-ahead FIFO with full/empty, almost-full/almost-empty
// threshold flags and an occupancy count.
// Optional sticky overflow/underflow error flags are built when the macro
// FIFO_THRESH_ERR_EN is defined; otherwise those outputs are tied low and
// err_clr is ignored.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            do_push, do_pop;
  thresh_flags_t   thr;

  // Occupancy flags come only from registered state; the extra pointer MSB
  // tells a full FIFO apart from an empty one.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]) &&
                 (rd_ptr_q[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0]);
  assign thr          = calc_thresh(32'(count_q), 32'(AF_LVL), 32'(AE_LVL));
  assign almost_full  = thr.almost_full;
  assign almost_empty = thr.almost_empty;
  assign count        = count_q;

  // Decide which transfers happen this edge; a pop at full frees the slot
  // for a same-edge push, while a read at empty is simply ignored.
  always_comb begin
    do_push  = wr && (!full || rd);
    do_pop   = rd && !empty;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset overrides any in-flight transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_push && !reset),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

`ifdef FIFO_THRESH_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a new error on the same edge as err_clr still sets.
  always_comb begin
    overflow_d  = (wr && full && !rd) || (overflow_q && !err_clr);
    underflow_d = (rd && empty) || (underflow_q && !err_clr);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
